// File: rtl/seg7_display_ctrl.sv
// Six-digit hex to seven-segment sequencer: decodes a 24-bit value and issues the
// five segment-row writes to the display driver, queuing at most one follow-up frame.
module seg7_display_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [23:0] value,
  input  logic        lz_blank,
  output logic        busy,
  output logic        done,
  output logic        write_enable,
  output logic        cs_7seg,
  output logic [31:0] address,
  output logic [31:0] data_write
);

  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3, W4, DONE} state_t;

  state_t state;
  state_t state_next;

  logic [23:0]       work_value;
  logic              work_lz;
  logic [23:0]       pend_value;
  logic              pend_lz;
  logic              pending;
  logic              in_write;
  logic              capture;
  logic              reload;
  logic [5:0][3:0]   digit;
  logic [5:0]        blank;
  logic [5:0][6:0]   seg;
  logic [4:0][11:0]  row;

  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] pattern;
    case (nib)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  assign in_write = (state == W0) || (state == W1) || (state == W2) ||
                    (state == W3) || (state == W4);
  assign capture  = req && ((state == IDLE) || (state == DONE));
  assign reload   = (state == DONE) && !req && pending;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = W0;
      W0:      state_next = W1;
      W1:      state_next = W2;
      W2:      state_next = W3;
      W3:      state_next = W4;
      W4:      state_next = DONE;
      DONE:    state_next = (req || pending) ? W0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Work registers stay frozen for a whole frame; mid-frame requests land in the
  // pending slot, last one wins, and the slot is consumed or dropped at DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_value <= '0;
      work_lz    <= 1'b0;
      pend_value <= '0;
      pend_lz    <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (capture) begin
        work_value <= value;
        work_lz    <= lz_blank;
      end else if (reload) begin
        work_value <= pend_value;
        work_lz    <= pend_lz;
      end

      if (in_write && req) begin
        pending    <= 1'b1;
        pend_value <= value;
        pend_lz    <= lz_blank;
      end else if (state == DONE) begin
        pending    <= 1'b0;
      end
    end
  end

  assign digit = work_value;

  // A digit is blanked when it and every digit above it are zero; hex0 always shows.
  assign blank = {work_lz && (work_value[23:20] == 4'h0),
                  work_lz && (work_value[23:16] == 8'h0),
                  work_lz && (work_value[23:12] == 12'h0),
                  work_lz && (work_value[23:8]  == 16'h0),
                  work_lz && (work_value[23:4]  == 20'h0),
                  1'b0};

  always_comb begin
    seg[0] = blank[0] ? 7'h7F : decode_hex(digit[0]);
    seg[1] = blank[1] ? 7'h7F : decode_hex(digit[1]);
    seg[2] = blank[2] ? 7'h7F : decode_hex(digit[2]);
    seg[3] = blank[3] ? 7'h7F : decode_hex(digit[3]);
    seg[4] = blank[4] ? 7'h7F : decode_hex(digit[4]);
    seg[5] = blank[5] ? 7'h7F : decode_hex(digit[5]);
  end

  assign row[0] = {6'b0, seg[0][0], seg[1][0], seg[2][0], seg[3][0], seg[4][0], seg[5][0]};
  assign row[1] = {seg[0][1], seg[0][5], seg[1][1], seg[1][5], seg[2][1], seg[2][5],
                   seg[3][1], seg[3][5], seg[4][1], seg[4][5], seg[5][1], seg[5][5]};
  assign row[2] = {6'b0, seg[0][6], seg[1][6], seg[2][6], seg[3][6], seg[4][6], seg[5][6]};
  assign row[3] = {seg[0][4], seg[0][2], seg[1][4], seg[1][2], seg[2][4], seg[2][2],
                   seg[3][4], seg[3][2], seg[4][4], seg[4][2], seg[5][4], seg[5][2]};
  assign row[4] = {6'b0, seg[0][3], seg[1][3], seg[2][3], seg[3][3], seg[4][3], seg[5][3]};

  // Output logic
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    write_enable = 1'b0;
    address      = '0;
    data_write   = '0;
    case (state)
      W0: begin
        write_enable = 1'b1;
        address      = BASE_ADDR;
        data_write   = {20'b0, row[0]};
      end
      W1: begin
        write_enable = 1'b1;
        address      = BASE_ADDR + 32'd1;
        data_write   = {20'b0, row[1]};
      end
      W2: begin
        write_enable = 1'b1;
        address      = BASE_ADDR + 32'd2;
        data_write   = {20'b0, row[2]};
      end
      W3: begin
        write_enable = 1'b1;
        address      = BASE_ADDR + 32'd3;
        data_write   = {20'b0, row[3]};
      end
      W4: begin
        write_enable = 1'b1;
        address      = BASE_ADDR + 32'd4;
        data_write   = {20'b0, row[4]};
      end
      default: ;
    endcase
    cs_7seg = write_enable;
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: directed and random frames checked against a
// digit-by-digit reference model of decode, blanking and row packing.
module tb_seg7_display_ctrl;

  localparam logic [31:0] BASE = 32'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [23:0] value = '0;
  logic        lz_blank = 1'b0;
  logic        busy;
  logic        done;
  logic        write_enable;
  logic        cs_7seg;
  logic [31:0] address;
  logic [31:0] data_write;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        r;
    logic [23:0] v;
    logic        lz;
  } stim_t;

  stim_t stim_q[$];

  int dec_tab[16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                      'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

  seg7_display_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .value        (value),
    .lz_blank     (lz_blank),
    .busy         (busy),
    .done         (done),
    .write_enable (write_enable),
    .cs_7seg      (cs_7seg),
    .address      (address),
    .data_write   (data_write)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scan digits from hex5 down, blanking while still in the leading-zero run.
  function automatic int model_row(input logic [23:0] v, input logic lz, input int r);
    int  seg[6];
    int  nib;
    int  res;
    bit  leading;
    leading = lz;
    for (int k = 5; k >= 0; k--) begin
      nib = int'(v >> (4 * k)) & 15;
      if (leading && nib == 0 && k != 0) begin
        seg[k] = 'h7F;
      end else begin
        leading = 1'b0;
        seg[k] = dec_tab[nib];
      end
    end
    res = 0;
    for (int k = 0; k < 6; k++) begin
      case (r)
        0: res |= ((seg[k] >> 0) & 1) << (5 - k);
        1: res |= (((seg[k] >> 1) & 1) << (11 - 2 * k)) | (((seg[k] >> 5) & 1) << (10 - 2 * k));
        2: res |= ((seg[k] >> 6) & 1) << (5 - k);
        3: res |= (((seg[k] >> 4) & 1) << (11 - 2 * k)) | (((seg[k] >> 2) & 1) << (10 - 2 * k));
        default: res |= ((seg[k] >> 3) & 1) << (5 - k);
      endcase
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive();
    stim_t s;
    if (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      req = s.r;
      value = s.v;
      lz_blank = s.lz;
    end else begin
      req = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_we"}, {31'b0, write_enable}, 32'd0);
    check({tag, "_cs"}, {31'b0, cs_7seg}, 32'd0);
    check({tag, "_addr"}, address, 32'd0);
    check({tag, "_data"}, data_write, 32'd0);
  endtask

  // Expects W0..W4 then DONE starting at the next cycle.
  task automatic burst(input logic [23:0] v, input logic lz, input string tag);
    for (int r = 0; r < 5; r++) begin
      tick();
      check($sformatf("%s_r%0d_we", tag, r), {31'b0, write_enable}, 32'd1);
      check($sformatf("%s_r%0d_cs", tag, r), {31'b0, cs_7seg}, 32'd1);
      check($sformatf("%s_r%0d_addr", tag, r), address, BASE + r);
      check($sformatf("%s_r%0d_data", tag, r), data_write, model_row(v, lz, r));
      check($sformatf("%s_r%0d_done", tag, r), {31'b0, done}, 32'd0);
      check($sformatf("%s_r%0d_busy", tag, r), {31'b0, busy}, 32'd1);
      drive();
    end
    tick();
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_done_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_done_we"}, {31'b0, write_enable}, 32'd0);
    check({tag, "_done_addr"}, address, 32'd0);
    check({tag, "_done_data"}, data_write, 32'd0);
    drive();
  endtask

  task automatic frame(input logic [23:0] v, input logic lz, input string tag);
    stim_q.push_back('{r: 1'b1, v: v, lz: lz});
    drive();
    burst(v, lz, tag);
    tick();
    check({tag, "_after_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_after_done"}, {31'b0, done}, 32'd0);
    drive();
  endtask

  initial begin
    logic [23:0] rv;
    logic        rlz;
    int          phase;
    int          n;

    repeat (2) tick();
    check_idle("in_reset");
    reset_n = 1'b1;
    tick();
    check_idle("post_reset");

    frame(24'h012345, 1'b0, "f012345");
    frame(24'h000000, 1'b1, "f000000_lz");
    frame(24'h888888, 1'b0, "f888888");
    frame(24'h000000, 1'b0, "f000000");
    frame(24'h000A00, 1'b1, "f000A00_lz");

    repeat (10) begin
      rv  = 24'($urandom) >> $urandom_range(0, 24);
      rlz = 1'($urandom_range(0, 1));
      frame(rv, rlz, "rand");
    end

    // A, then B and C while busy: C must follow A directly, B never rendered.
    stim_q.push_back('{r: 1'b1, v: 24'h111111, lz: 1'b0});
    stim_q.push_back('{r: 1'b0, v: 24'h111111, lz: 1'b0});
    stim_q.push_back('{r: 1'b1, v: 24'h222222, lz: 1'b0});
    stim_q.push_back('{r: 1'b1, v: 24'h333333, lz: 1'b0});
    drive();
    burst(24'h111111, 1'b0, "bbA");
    burst(24'h333333, 1'b0, "bbC");
    tick();
    check("bb_idle_busy", {31'b0, busy}, 32'd0);
    check("bb_idle_done", {31'b0, done}, 32'd0);
    drive();

    // Asynchronous reset during W2 with a pending request queued.
    stim_q.push_back('{r: 1'b1, v: 24'h444444, lz: 1'b0});
    stim_q.push_back('{r: 1'b1, v: 24'h555555, lz: 1'b0});
    drive();
    tick();
    check("rst_w0_we", {31'b0, write_enable}, 32'd1);
    drive();
    tick();
    drive();
    tick();
    check("rst_w2_addr", address, BASE + 32'd2);
    #1 reset_n = 1'b0;
    #1 check_idle("rst_async");
    tick();
    tick();
    reset_n = 1'b1;
    stim_q.delete();
    req = 1'b0;
    repeat (8) begin
      tick();
      check_idle("rst_after");
    end

    // Held request re-renders every 6 cycles.
    repeat (21) stim_q.push_back('{r: 1'b1, v: 24'h00A5C3, lz: 1'b1});
    drive();
    for (int c = 1; c <= 20; c++) begin
      tick();
      phase = (c - 1) % 6;
      check($sformatf("hold_c%0d_we", c), {31'b0, write_enable}, {31'b0, phase < 5});
      check($sformatf("hold_c%0d_cs", c), {31'b0, cs_7seg}, {31'b0, write_enable});
      check($sformatf("hold_c%0d_done", c), {31'b0, done}, {31'b0, phase == 5});
      if (phase < 5) begin
        check($sformatf("hold_c%0d_addr", c), address, BASE + phase);
        check($sformatf("hold_c%0d_data", c), data_write, model_row(24'h00A5C3, 1'b1, phase));
      end
      drive();
    end
    n = 0;
    while (busy !== 1'b0 && n < 16) begin
      tick();
      drive();
      n++;
    end
    check("hold_drain_busy", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Sequencer that takes a 6-digit hexadecimal value and renders it onto the six seven-segment displays. It decodes each nibble to an active-low segment pattern and issues the five segment-row bus writes (addresses BASE_ADDR..BASE_ADDR+4) that the seven-segment driver expects. It sits between a software-visible or hardwired requester and the driver's write port, and owns that port exclusively.

## Interface

- BASE_ADDR, 3: driver address of the segment-a row; rows a, b/f, g, e/c, d follow at +0..+4.
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  display request; sampled every edge.
- value  in  24  digits; value[4k+3:4k] is shown on hex k (hex0 = value[3:0]).
- lz_blank  in  1  leading-zero blanking enable, captured with value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last row write.
- write_enable  out  1  driver write strobe.
- cs_7seg  out  1  driver chip select; equal to write_enable.
- address  out  32  driver address.
- data_write  out  32  driver write data; bits 31:12 always 0.

## Operation

- Segment bit order per digit: bit0=a … bit6=g. Active-low (0 = lit). Decode 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- Blanked digit = 7F. With lz_blank=1, digits are blanked from hex5 downward while zero, stopping at the first nonzero digit; hex0 is never blanked.
- Row packing (digit k's bit s written as hk[s]):
  - BASE+0: data[5:0] = {h0[0],h1[0],h2[0],h3[0],h4[0],h5[0]}.
  - BASE+1: data[11:0] = {h0[1],h0[5],h1[1],h1[5],…,h5[1],h5[5]}.
  - BASE+2: data[5:0] = {h0[6],…,h5[6]}.
  - BASE+3: data[11:0] = {h0[4],h0[2],h1[4],h1[2],…,h5[4],h5[2]}.
  - BASE+4: data[5:0] = {h0[3],…,h5[3]}. Unused bits 0.
- FSM: IDLE, W0, W1, W2, W3, W4, DONE.
  - IDLE: req=1 → capture value/lz_blank into work regs, go W0.
  - Wn: write_enable=cs_7seg=1, address=BASE_ADDR+n, data per row n; advance to W(n+1); W4 → DONE.
  - DONE: done=1. If req=1 → capture inputs, go W0. Else if pending → load pending regs, go W0. Else → IDLE. Pending is cleared on either reload.
- Requests while busy (W0..W4): set pending and store value/lz_blank into pending regs; later requests overwrite (last value wins). Work regs never change mid-sequence.
- Outside W0..W4: write_enable=cs_7seg=0, address=0, data_write=0.
- Outputs depend only on registered state; no combinational path from req/value.
- data_read from the driver is not used.

## Timing

- Reset (async, any state): state=IDLE, pending=0, work/pending regs=0, busy=0, done=0, write_enable=cs_7seg=0, address=0, data_write=0. A partial write sequence is abandoned; the driver keeps the rows already written.
- Latency: req sampled at edge E → row writes are presented in cycles E+1..E+5 (committed by the driver at edges E+1..E+5), done is high in cycle E+6, and busy is high in cycles E+1..E+6.
- Back-to-back: with a pending or DONE-cycle request, the next W0 follows DONE directly. That is 6 cycles per frame, with no IDLE cycle.
- A req held high continuously re-renders every 6 cycles.

## Test plan

- value=012345, lz_blank=0 → writes (addr, data) = (3,0x12),(4,—),(5,0x03),(6,—),(7,0x12) on 5 consecutive cycles. The bench checks all five rows against its own decode model. done pulses one cycle after addr 7 is presented.
- value=000000, lz_blank=1 → addr3 data 0x1F, addr5 data 0x3F, addr7 data 0x1F; hex0 shows "0" and hex1-hex5 are blank.
- value=888888 → all five writes carry data 0; value=000000 with lz_blank=0 → addr5 data 0x3F, addr3 data 0x00.
- req with A=111111 at E, then req with B=222222 at E+2 and C=333333 at E+3 → frame A completes, DONE goes straight to W0 with C, B is never written, and a single done pulse occurs per frame.
- Deassert reset_n asynchronously during W2 → all outputs 0 immediately. After release, IDLE with busy=0; no done pulse and no pending replay.
- req held 1 for 20 cycles → a write burst starts every 6 cycles, and write_enable always equals cs_7seg.
